// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the iterative RV32M divider.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } div_state_e;

  localparam int DIV_OP_SIGNED = 0;
  localparam int DIV_OP_REM    = 1;
  localparam int DIV_STEPS     = 32;
  localparam int DIV_CNT_W     = 5;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_Q  = 32'h8000_0000;

  localparam logic [1:0] ADD_OP_SUBU = 2'b10;

  // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/adder.sv
// Shared 32-bit add/subtract unit: op 00 adds, 01 subtracts with a signed
// compare, 10/11 subtract with an unsigned compare; lt flags a < b.
module adder (
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] c,
  output logic        lt
);

  logic [32:0] diff;
  logic [31:0] sum;

  assign diff = {1'b0, a} - {1'b0, b};
  assign sum  = a + b;
  assign c    = (op == 2'b00) ? sum : diff[31:0];
  // With equal sign bits the unsigned borrow is also the signed ordering.
  assign lt   = (op == 2'b01 && (a[31] ^ b[31])) ? a[31] : diff[32];

endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_FASTPATH_EN to finish divide-by-zero and signed overflow in one cycle.
module div_seq
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [31:0]          r_q, q_q, abs_b_q;
  logic                 sign_a_q, sign_b_q, is_rem_q, b_zero_q;

  logic        accept, in_sign_a, in_sign_b;
  logic [32:0] rs;
  logic        step_ok;
  logic [31:0] add_a, add_b, add_c;
  logic        add_lt;
  logic [31:0] fix_v, fix_res;
  logic        fix_neg;

  assign accept    = (state_q == IDLE) & start & ~flush;
  assign in_sign_a = op[DIV_OP_SIGNED] & a[31];
  assign in_sign_b = op[DIV_OP_SIGNED] & b[31];

  assign rs      = {r_q, q_q[31]};
  assign step_ok = rs[32] | ~add_lt;

  assign fix_v   = is_rem_q ? r_q : q_q;
  assign fix_neg = is_rem_q ? sign_a_q : (sign_a_q ^ sign_b_q);
  // A zero divisor leaves R = |a|, so the remainder already comes out as a.
  assign fix_res = (b_zero_q & ~is_rem_q) ? DIV_ZERO_Q : (fix_neg ? add_c : fix_v);

`ifdef DIV_FASTPATH_EN
  logic        fast_hit;
  logic [31:0] fast_res;

  assign fast_hit = (b == '0) | (op[DIV_OP_SIGNED] & (a == DIV_OVF_Q) & (b == '1));
  assign fast_res = (b == '0) ? (op[DIV_OP_REM] ? a : DIV_ZERO_Q)
                              : (op[DIV_OP_REM] ? '0 : DIV_OVF_Q);
`endif

  always_comb begin
    add_a = rs[31:0];
    add_b = abs_b_q;
    if (state_q == FIX) begin
      add_a = '0;
      add_b = fix_v;
    end
  end

  adder u_adder (
    .op (ADD_OP_SUBU),
    .a  (add_a),
    .b  (add_b),
    .c  (add_c),
    .lt (add_lt)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    busy    = (state_q == CALC) | (state_q == FIX);
    done    = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef DIV_FASTPATH_EN
          state_d = fast_hit ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      abs_b_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_rem_q <= 1'b0;
      b_zero_q <= 1'b0;
      result   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            is_rem_q <= op[DIV_OP_REM];
            b_zero_q <= (b == '0);
            q_q      <= abs32(a, in_sign_a);
            abs_b_q  <= abs32(b, in_sign_b);
            r_q      <= '0;
            cnt_q    <= DIV_CNT_W'(DIV_STEPS - 1);
`ifdef DIV_FASTPATH_EN
            if (fast_hit) result <= fast_res;
`endif
          end
        end
        CALC: begin
          r_q   <= step_ok ? add_c : rs[31:0];
          q_q   <= {q_q[30:0], step_ok};
          cnt_q <= cnt_q - DIV_CNT_W'(1);
        end
        FIX:     if (!flush) result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus randomized traffic against
// a cycle-timeline reference model built from plain integer division.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

`ifdef DIV_FASTPATH_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  always #5 clk = ~clk;

  div_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0]        q, r;
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (o[0]) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = x;
        r = 32'd0;
      end else begin
        q = sx / sy;
        r = sx % sy;
      end
    end else begin
      q = x / y;
      r = x % y;
    end
    return o[1] ? r : q;
  endfunction

  function automatic bit is_fast(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_FASTPATH_EN
    return (y == 32'd0) || (o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
`else
    return 1'b0 & o[0] & x[0] & y[0];
`endif
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Timeline model: an accepted operation is "age" cycles old; done in the
  // cycle age == lat, busy before that, result published entering done.
  bit          m_pending = 1'b0;
  int          m_age     = 0;
  int          m_lat     = 34;
  logic [31:0] m_exp     = '0;
  logic [31:0] m_result  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending <= 1'b0;
      m_age     <= 0;
      m_result  <= '0;
    end else if (m_pending) begin
      if (m_age == m_lat || flush) begin
        m_pending <= 1'b0;
      end else begin
        m_age <= m_age + 1;
        if (m_age + 1 == m_lat) m_result <= m_exp;
      end
    end else if (start && !flush) begin
      m_pending <= 1'b1;
      m_age     <= 1;
      m_exp     <= ref_result(op, a, b);
      m_lat     <= is_fast(op, a, b) ? 1 : 34;
      if (is_fast(op, a, b)) m_result <= ref_result(op, a, b);
    end
  end

  always @(negedge clk) begin
    check("model busy",   32'(busy),   32'(m_pending && (m_age < m_lat)));
    check("model done",   32'(done),   32'(m_pending && (m_age == m_lat)));
    check("model result", result,      m_result);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    step();
    start = 1'b0;
  endtask

  // k0 is the cycle number (relative to the accepting cycle 0) we are in now.
  task automatic wait_done(input string name, input int k0, input int exp_cyc, input logic [31:0] exp_res);
    int k;
    k = k0;
    while (!done && k < 80) begin
      step();
      k++;
    end
    check({name, " done cycle"}, 32'(k), 32'(exp_cyc));
    check({name, " result"}, result, exp_res);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_done;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    check("reset busy",   32'(busy), 32'd0);
    check("reset done",   32'(done), 32'd0);
    check("reset result", result,    32'd0);
    step();

    issue(2'b00, 32'd100, 32'd7);
    wait_done("divu 100/7", 1, 34, 32'd14);
    issue(2'b10, 32'd100, 32'd7);
    wait_done("remu 100/7", 1, 34, 32'd2);
    issue(2'b01, 32'hFFFF_FFF9, 32'd2);
    wait_done("div -7/2", 1, 34, 32'hFFFF_FFFD);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done("rem -7/2", 1, 34, 32'hFFFF_FFFF);

    // Flush in cycle 10, restart in cycle 11.
    issue(2'b00, 32'd1000, 32'd3);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy",   32'(busy), 32'd0);
    check("flush done",   32'(done), 32'd0);
    check("flush result", result,    32'hFFFF_FFFF);
    issue(2'b00, 32'd9, 32'd4);
    wait_done("divu 9/4 after flush", 12, 45, 32'd2);

    // Start pulsed in cycle 5 while busy must be ignored.
    issue(2'b00, 32'd1000, 32'd3);
    repeat (4) step();
    start = 1'b1;
    op    = 2'b11;
    a     = 32'd5;
    b     = 32'd1;
    step();
    start = 1'b0;
    wait_done("start while busy", 6, 34, 32'd333);

    // Asynchronous reset in cycle 20.
    issue(2'b00, 32'd1000, 32'd3);
    repeat (19) step();
    #1 rst = 1'b1;
    #1;
    check("async rst busy",   32'(busy), 32'd0);
    check("async rst done",   32'(done), 32'd0);
    check("async rst result", result,    32'd0);
    step();
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      step();
      if (done) n_done++;
    end
    check("no done after rst", 32'(n_done), 32'd0);

    issue(2'b01, 32'h1234_5678, 32'd0);
    wait_done("div by zero", 1, ZLAT, 32'hFFFF_FFFF);
    issue(2'b10, 32'h1234_5678, 32'd0);
    wait_done("remu by zero", 1, ZLAT, 32'h1234_5678);
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div overflow", 1, ZLAT, 32'h8000_0000);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("rem overflow", 1, ZLAT, 32'd0);

    // Random traffic: starts, stray starts while busy and occasional flushes.
    repeat (2500) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom);
      a     = rnd_word();
      b     = rnd_word();
      flush = ($urandom_range(0, 59) == 0);
      step();
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit divider sequencer for the RV32M DIV/DIVU/REM/REMU instructions in the miniRV pipeline EX stage. It owns one `adder` instance and drives it for two purposes: unsigned subtraction during each restoring-division step, and two's-complement negation for the final sign fix. The EX stage holds the instruction while `busy` is high, and the block returns one 32-bit result with a single-cycle `done` pulse.

## Interface
- Parameters: none. The datapath is fixed at 32 bits to match `adder`.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: launch a divide. Sampled only in IDLE.
- `op` in 2: `op[0]` = 1 for signed; `op[1]` = 1 for remainder, 0 for quotient.
- `a` in 32: dividend, captured on an accepted start.
- `b` in 32: divisor, captured on an accepted start.
- `flush` in 1: abort the current operation (pipeline redirect).
- `busy` out 1: high while an operation is in progress.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 32: registered result, held until the next `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, `start`=1, `flush`=0:
  - Capture `op`, sign_a = `op[0]`&`a[31]`, sign_b = `op[0]`&`b[31]`.
  - Capture |a| and |b|, negated locally (not through the adder).
  - Q <= |a|, R <= 0, cnt <= 31; go to CALC.
- CALC, one step per cycle:
  - Rs = {R,Q[31]} (33 bits).
  - Adder: op=2'b10, a=Rs[31:0], b=|b|.
  - Step is accepted when Rs[32] | ~lt. Then R <= c, else R <= Rs[31:0].
  - Q <= {Q[30:0], accepted}.
  - cnt decrements; leave for FIX after the cnt==0 step.
- FIX:
  - v = `op[1]` ? R : Q.
  - neg = `op[1]` ? sign_a : (sign_a ^ sign_b).
  - If neg, the adder computes 0 − v (op=2'b10, a=0, b=v); otherwise v passes through.
  - `result` <= that value; go to DONE.
- Divide by zero (b==0), overriding FIX: quotient = 0xFFFFFFFF, remainder = a as originally captured (signed or not).
- Signed overflow (0x80000000 / 0xFFFFFFFF) needs no special case: quotient 0x80000000, remainder 0.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `flush` in any state forces IDLE next cycle:
  - No `done`; `result` is unchanged.
  - `flush` together with `start` in IDLE: `flush` wins, nothing is accepted.
- `start` in CALC, FIX or DONE is ignored. The EX stage must not issue while `busy`.
- Adder operands when not in CALC or FIX: don't-care, but must not feed any output.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0x00000000, cnt=0, R=Q=0.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronously); there is no `done`.
- Start accepted in cycle 0:
  - CALC in cycles 1–32.
  - FIX in cycle 33.
  - `done`=1 in cycle 34.
  - Earliest next accepted start: cycle 35.
- `busy` = (state==CALC) | (state==FIX), registered with the state. `busy` is 0 in DONE.
- `result` changes only on the edge entering DONE.

## Configuration
- Macro `DIV_FASTPATH_EN`.
- Defined: in IDLE, b==0, or signed 0x80000000 / 0xFFFFFFFF, goes straight to DONE.
  - `result` loads the special-case value on the accepting edge.
  - `done`=1 in cycle 1; `busy` stays 0.
- Undefined: every operation takes the full 34-cycle path, with special cases resolved in FIX.

## Structure
- Shared package `div_pkg`:
  - State encoding localparams (IDLE/CALC/FIX/DONE).
  - Op bit positions `DIV_OP_SIGNED`=0 and `DIV_OP_REM`=1.
  - `DIV_STEPS`=32 and `DIV_CNT_W`=5.
  - Constants `DIV_ZERO_Q`=32'hFFFFFFFF and `DIV_OVF_Q`=32'h80000000.
- Single sub-module: the existing `adder`, instantiated once. Its `op` is always 2'b10 (unsigned subtract).
- Abs-value logic and the FSM live in `div_seq`.

## Test plan
- DIVU a=100, b=7: `done` at cycle 34, result 14. REMU with the same operands: result 2.
- DIV a=0xFFFFFFF9 (−7), b=2: result 0xFFFFFFFD. REM: result 0xFFFFFFFF.
- DIV a=0x12345678, b=0: result 0xFFFFFFFF. REMU: result 0x12345678.
  - `done` at cycle 1 with `DIV_FASTPATH_EN`, cycle 34 without.
- DIV a=0x80000000, b=0xFFFFFFFF: result 0x80000000. REM: result 0.
- Start DIVU 1000/3, then `flush` in cycle 10:
  - `busy`=0 in cycle 11 and no `done`; `result` keeps its prior value.
  - Start in cycle 11 with DIVU 9/4: `done` at cycle 45, result 2.
- Pulse `start` in cycle 5 while `busy`: ignored, and the original result is unaffected.
- Assert `rst` in cycle 20: `busy`/`done`/`result` go to 0 asynchronously, with no `done` afterwards.
